// File: rtl/mito_seq_if.sv
// mito_seq_if: groups the source handshake, buffer write strobes, window marker
// and MAC result tag into one bundle for the convolution sequencer.
//
// Handshake rule: a source beat transfers on a rising clk edge exactly when
// src_valid and src_ready are both 1. The source may raise or drop src_valid
// at will. The controller never qualifies src_ready on src_valid. Every buffer
// strobe (wgt_read, bias_read, ifm_read) is asserted only in a transfer cycle.
//
// Signals
//   src_valid   source -> ctrl   beat available (weight, bias or IFM column)
//   src_ready   ctrl -> source   controller accepts a beat this cycle
//   wgt_read    ctrl -> dp       weight buffer write strobe
//   bias_read   ctrl -> dp       bias buffer write strobe
//   ifm_read    ctrl -> dp       one-hot IFM column-slot write strobe
//   win_valid   ctrl -> dp       3x3 window complete, MAC may fire
//   win_oldest  ctrl -> dp       slot index of the oldest column in the window
//   ofm_valid   ctrl -> dp       MAC result valid
//   ofm_row     ctrl -> dp       output row of the current result
//   ofm_col     ctrl -> dp       output column of the current result
// Modports: master = sequencer side, slave = source/datapath side.
interface mito_seq_if #(
  parameter int DIM_W = 8
);
  logic             src_valid;
  logic             src_ready;
  logic             wgt_read;
  logic             bias_read;
  logic [2:0]       ifm_read;
  logic             win_valid;
  logic [1:0]       win_oldest;
  logic             ofm_valid;
  logic [DIM_W-1:0] ofm_row;
  logic [DIM_W-1:0] ofm_col;

  modport master (
    input  src_valid,
    output src_ready, wgt_read, bias_read, ifm_read,
    output win_valid, win_oldest, ofm_valid, ofm_row, ofm_col
  );

  modport slave (
    output src_valid,
    input  src_ready, wgt_read, bias_read, ifm_read,
    input  win_valid, win_oldest, ofm_valid, ofm_row, ofm_col
  );
endinterface

// File: rtl/mito_seq_ctrl.sv
// mito_seq_ctrl: sequencer for the 3x3 convolution datapath.
// It loads 3 weight beats and 1 bias beat. It then streams IFM column beats
// (3 rows each) into a 3-slot rotating column buffer. It marks each complete
// 3x3 window for the MAC array and tags the MAC results with their output
// row and column after a fixed MAC latency.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start_i       job start pulse, honoured only while idle
//   cfg_ifm_w_i   IFM width in columns, latched on an accepted start
//   cfg_ifm_h_i   IFM height in rows, latched on an accepted start
//   bus           mito_seq_if master: source handshake, strobes, window, result
//   busy_o        job in progress
//   done_o        one-cycle pulse when the job's last result has left
//   err_cfg_o     one-cycle pulse when a start is rejected (w<3 or h<3)
//   dbg_state_o   current FSM state encoding
module mito_seq_ctrl #(
  parameter int DIM_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIM_W-1:0] cfg_ifm_w_i,
  input  logic [DIM_W-1:0] cfg_ifm_h_i,
  mito_seq_if.master       bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_cfg_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WGT  = 3'd1,
    S_LD_BIAS = 3'd2,
    S_STREAM  = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [DIM_W-1:0] C1 = DIM_W'(1);
  localparam logic [DIM_W-1:0] C2 = DIM_W'(2);
  localparam logic [DIM_W-1:0] C3 = DIM_W'(3);

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [DIM_W-1:0] col_q, col_d, pass_q, pass_d;
  logic [1:0]       slot_q, slot_d;

  logic             win_valid_q, win_valid_d;
  logic [1:0]       win_oldest_q, win_oldest_d;
  logic [DIM_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;

  logic             done_q, done_d;
  logic             err_q, err_d;

  // Fixed-length delay line that models the MAC latency. It shifts every
  // cycle, stalls included, so results keep their latency to win_valid.
  logic             pipe_v_q [MAC_LAT];
  logic [DIM_W-1:0] pipe_r_q [MAC_LAT];
  logic [DIM_W-1:0] pipe_c_q [MAC_LAT];

  logic             src_ready;
  logic             wgt_read;
  logic             bias_read;
  logic [2:0]       ifm_read;
  logic             ofm_valid;
  logic [DIM_W-1:0] ofm_row, ofm_col;

  assign ofm_valid = pipe_v_q[MAC_LAT-1];
  assign ofm_row   = pipe_r_q[MAC_LAT-1];
  assign ofm_col   = pipe_c_q[MAC_LAT-1];

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    wcnt_d       = wcnt_q;
    col_d        = col_q;
    pass_d       = pass_q;
    slot_d       = slot_q;
    win_valid_d  = 1'b0;
    win_oldest_d = 2'd0;
    win_row_d    = '0;
    win_col_d    = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    src_ready    = 1'b0;
    wgt_read     = 1'b0;
    bias_read    = 1'b0;
    ifm_read     = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((cfg_ifm_w_i < C3) || (cfg_ifm_h_i < C3)) begin
            err_d = 1'b1;
          end else begin
            w_d     = cfg_ifm_w_i;
            h_d     = cfg_ifm_h_i;
            wcnt_d  = 2'd0;
            col_d   = '0;
            pass_d  = '0;
            slot_d  = 2'd0;
            state_d = S_LD_WGT;
          end
        end
      end

      S_LD_WGT: begin
        src_ready = 1'b1;
        wgt_read  = bus.src_valid;
        if (bus.src_valid) begin
          if (wcnt_q == 2'd2) begin
            wcnt_d  = 2'd0;
            state_d = S_LD_BIAS;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end

      S_LD_BIAS: begin
        src_ready = 1'b1;
        bias_read = bus.src_valid;
        if (bus.src_valid) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        src_ready = 1'b1;
        if (bus.src_valid) begin
          ifm_read = 3'b001 << slot_q;
          // The third column of a pass completes the first window. From then
          // on each column completes one more. The oldest column sits in the
          // slot after the one just written.
          if (col_q >= C2) begin
            win_valid_d  = 1'b1;
            win_oldest_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
            win_row_d    = pass_q;
            win_col_d    = col_q - C2;
          end
          if (col_q == w_q - C1) begin
            col_d  = '0;
            slot_d = 2'd0;
            if (pass_q == h_q - C3) begin
              state_d = S_DRAIN;
            end else begin
              pass_d = pass_q + C1;
            end
          end else begin
            col_d  = col_q + C1;
            slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
          end
        end
      end

      S_DRAIN: begin
        // Only this job's results can be in flight, so the last raster tag
        // identifies the final result.
        if (ofm_valid && (ofm_row == h_q - C3) && (ofm_col == w_q - C3)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      wcnt_q       <= 2'd0;
      col_q        <= '0;
      pass_q       <= '0;
      slot_q       <= 2'd0;
      win_valid_q  <= 1'b0;
      win_oldest_q <= 2'd0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      wcnt_q       <= wcnt_d;
      col_q        <= col_d;
      pass_q       <= pass_d;
      slot_q       <= slot_d;
      win_valid_q  <= win_valid_d;
      win_oldest_q <= win_oldest_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_r_q[i] <= '0;
        pipe_c_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0] <= win_valid_q;
      pipe_r_q[0] <= win_row_q;
      pipe_c_q[0] <= win_col_q;
      for (int i = 1; i < MAC_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_r_q[i] <= pipe_r_q[i-1];
        pipe_c_q[i] <= pipe_c_q[i-1];
      end
    end
  end

  assign bus.src_ready  = src_ready;
  assign bus.wgt_read   = wgt_read;
  assign bus.bias_read  = bias_read;
  assign bus.ifm_read   = ifm_read;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_oldest = win_oldest_q;
  assign bus.ofm_valid  = ofm_valid;
  assign bus.ofm_row    = ofm_row;
  assign bus.ofm_col    = ofm_col;

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_cfg_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mito_seq_ctrl.sv
// tb_mito_seq_ctrl: randomized bench for mito_seq_ctrl. A beat-index model
// predicts every output on every cycle. Per-job literal checks pin the model.
module tb_mito_seq_ctrl;
  localparam int DIM_W   = 8;
  localparam int MAC_LAT = 3;
  localparam int RING    = 32;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] cfg_w, cfg_h;
  logic             busy, done, err_cfg;
  logic [2:0]       dbg_state;

  mito_seq_if #(.DIM_W(DIM_W)) bus ();

  mito_seq_ctrl #(.DIM_W(DIM_W), .MAC_LAT(MAC_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .cfg_ifm_w_i (cfg_w),
    .cfg_ifm_h_i (cfg_h),
    .bus         (bus.master),
    .busy_o      (busy),
    .done_o      (done),
    .err_cfg_o   (err_cfg),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model state ----------------
  // A job is a list of beats: 3 weights, 1 bias, then w*(h-2) IFM columns.
  // Beat k>=4 is column (k-4)%w of pass (k-4)/w.
  bit              m_busy = 1'b0;
  int              m_w = 0, m_h = 0, m_beats = 0, m_total = 0;
  int              m_end = -1;
  bit              ring_ofm [RING];
  bit              wp = 1'b0;
  int              wp_old = 0;
  bit              ep = 1'b0;
  logic [15:0]     exp_q [$];

  // ---------------- observation counters (monitor-written only) ----------------
  int          obs_wgt = 0, obs_bias = 0, obs_ifm = 0, obs_win = 0, obs_ofm = 0;
  int          obs_done = 0, obs_err = 0, obs_busy = 0;
  int          last_win_cyc = 0, last_ofm_cyc = 0, last_done_cyc = 0, last_win_old = 0;
  logic [15:0] last_ofm_tag = '0;
  logic [2:0]  ifm_hist [$];

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    bit         e_ready, bt;
    logic [2:0] e_ifm;
    logic [15:0] e_tag;
    int         k, col;

    e_ready = m_busy && (m_beats < m_total);
    bt      = e_ready && (bus.src_valid === 1'b1);
    k       = m_beats - 4;
    col     = (k >= 0 && m_w > 0) ? (k % m_w) : 0;
    e_ifm   = (bt && m_beats >= 4) ? (3'b001 << (col % 3)) : 3'b000;

    if (rst !== 1'b1 || cyc > 0) begin
      chk("busy",       32'(busy),          32'(m_busy));
      chk("src_ready",  32'(bus.src_ready), 32'(e_ready));
      chk("wgt_read",   32'(bus.wgt_read),  32'(bt && m_beats < 3));
      chk("bias_read",  32'(bus.bias_read), 32'(bt && m_beats == 3));
      chk("ifm_read",   32'(bus.ifm_read),  32'(e_ifm));
      chk("win_valid",  32'(bus.win_valid), 32'(wp));
      if (wp) chk("win_oldest", 32'(bus.win_oldest), 32'(wp_old));
      chk("ofm_valid",  32'(bus.ofm_valid), 32'(ring_ofm[cyc % RING]));
      if (ring_ofm[cyc % RING]) begin
        if (exp_q.size() == 0) begin
          chk("ofm_tag_queue_empty", 32'(1), 32'(0));
        end else begin
          e_tag = exp_q.pop_front();
          chk("ofm_tag", 32'({bus.ofm_row, bus.ofm_col}), 32'(e_tag));
        end
      end
      chk("done",    32'(done),    32'((m_end >= 0) && (cyc == m_end)));
      chk("err_cfg", 32'(err_cfg), 32'(ep));
    end

    // observations
    obs_wgt  += int'(bus.wgt_read);
    obs_bias += int'(bus.bias_read);
    obs_busy += int'(busy);
    if (bus.ifm_read != 3'b000) begin obs_ifm++; ifm_hist.push_back(bus.ifm_read); end
    if (bus.win_valid) begin obs_win++; last_win_cyc = cyc; last_win_old = int'(bus.win_oldest); end
    if (bus.ofm_valid) begin obs_ofm++; last_ofm_cyc = cyc; last_ofm_tag = {bus.ofm_row, bus.ofm_col}; end
    if (done) begin obs_done++; last_done_cyc = cyc; end
    if (err_cfg) obs_err++;

    // advance the model to the next cycle
    ring_ofm[cyc % RING] = 1'b0;
    wp = 1'b0;
    ep = 1'b0;
    if (bt) begin
      if (m_beats >= 4 && col >= 2) begin
        wp     = 1'b1;
        wp_old = (col + 1) % 3;
        ring_ofm[(cyc + 1 + MAC_LAT) % RING] = 1'b1;
        if (k == m_total - 5) m_end = cyc + 2 + MAC_LAT;
      end
      m_beats++;
    end
    if (!m_busy && start === 1'b1) begin
      if (int'(cfg_w) < 3 || int'(cfg_h) < 3) begin
        ep = 1'b1;
      end else begin
        m_busy  = 1'b1;
        m_w     = int'(cfg_w);
        m_h     = int'(cfg_h);
        m_beats = 0;
        m_total = 4 + m_w * (m_h - 2);
        m_end   = -1;
        for (int r = 0; r <= m_h - 3; r++)
          for (int c = 0; c <= m_w - 3; c++)
            exp_q.push_back({8'(r), 8'(c)});
      end
    end
    if (m_end >= 0 && cyc + 1 == m_end) m_busy = 1'b0;
    if (rst === 1'b1) begin
      m_busy  = 1'b0;
      m_beats = 0;
      m_total = 0;
      m_end   = -1;
      wp      = 1'b0;
      ep      = 1'b0;
      exp_q.delete();
      for (int i = 0; i < RING; i++) ring_ofm[i] = 1'b0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int w, input int h);
    cfg_w = 8'(w);
    cfg_h = 8'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive random src_valid until a done pulse is seen. Optionally pulse a
  // stray start at cycle poke_at.
  task automatic stream_until_done(input int pct, input int poke_at);
    int n;
    int d0;
    n  = 0;
    d0 = obs_done;
    while (obs_done == d0 && n < 2000) begin
      bus.src_valid = ($urandom_range(0, 99) < pct);
      if (n == poke_at) begin
        cfg_w = 8'd9;
        cfg_h = 8'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start         = 1'b0;
    bus.src_valid = 1'b0;
    if (n >= 2000) chk("done_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- directed sequence ----------------
  int b_wgt, b_bias, b_ifm, b_win, b_ofm, b_done, b_err, b_busy, b_hist;
  int slots5 [5];

  task automatic snap();
    b_wgt  = obs_wgt;  b_bias = obs_bias; b_ifm = obs_ifm; b_win = obs_win;
    b_ofm  = obs_ofm;  b_done = obs_done; b_err = obs_err; b_busy = obs_busy;
    b_hist = ifm_hist.size();
  endtask

  initial begin
    slots5 = '{1, 2, 4, 1, 2};
    rst = 1'b1;
    start = 1'b0;
    cfg_w = '0;
    cfg_h = '0;
    bus.src_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_busy",      32'(busy),          32'(0));
    chk("rst_src_ready", 32'(bus.src_ready), 32'(0));
    chk("rst_ofm_valid", 32'(bus.ofm_valid), 32'(0));
    chk("rst_done",      32'(done),          32'(0));

    // T1: w=5 h=4, no stalls
    snap();
    start_job(5, 4);
    stream_until_done(100, -1);
    chk("t1_wgt",  32'(obs_wgt - b_wgt),   32'(3));
    chk("t1_bias", 32'(obs_bias - b_bias), 32'(1));
    chk("t1_ifm",  32'(obs_ifm - b_ifm),   32'(10));
    chk("t1_ofm",  32'(obs_ofm - b_ofm),   32'(6));
    for (int i = 0; i < 10; i++)
      chk("t1_slot", 32'(ifm_hist[b_hist + i]), 32'(slots5[i % 5]));
    chk("t1_last_tag",  32'(last_ofm_tag), 32'(16'h0102));
    chk("t1_done_lag",  32'(last_done_cyc - last_ofm_cyc), 32'(1));

    // T2: minimal 3x3
    tick();
    snap();
    start_job(3, 3);
    stream_until_done(100, -1);
    chk("t2_win",     32'(obs_win - b_win), 32'(1));
    chk("t2_oldest",  32'(last_win_old),    32'(0));
    chk("t2_ofm",     32'(obs_ofm - b_ofm), 32'(1));
    chk("t2_tag",     32'(last_ofm_tag),    32'(0));
    chk("t2_latency", 32'(last_ofm_cyc - last_win_cyc), 32'(3));

    // T3: w=6 h=5, 50% valid
    tick();
    snap();
    start_job(6, 5);
    stream_until_done(50, -1);
    chk("t3_ofm", 32'(obs_ofm - b_ofm), 32'(12));
    chk("t3_ifm", 32'(obs_ifm - b_ifm), 32'(18));
    chk("t3_wgt", 32'(obs_wgt - b_wgt), 32'(3));

    // T4: rejected configs, then a stray start while busy
    tick();
    snap();
    start_job(2, 8);
    repeat (4) tick();
    start_job(8, 2);
    repeat (4) tick();
    chk("t4_err",  32'(obs_err - b_err),   32'(2));
    chk("t4_busy", 32'(obs_busy - b_busy), 32'(0));
    chk("t4_strb", 32'(obs_wgt - b_wgt + obs_ifm - b_ifm), 32'(0));
    snap();
    start_job(4, 3);
    stream_until_done(100, 8);
    repeat (10) tick();
    chk("t4_jobs",     32'(obs_done - b_done), 32'(1));
    chk("t4_ofm",      32'(obs_ofm - b_ofm),   32'(2));
    chk("t4_idle_end", 32'(busy),              32'(0));

    // T5: reset during STREAM
    snap();
    start_job(5, 4);
    bus.src_valid = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.src_valid = 1'b0;
    chk("t5_busy0",  32'(busy),          32'(0));
    chk("t5_ready0", 32'(bus.src_ready), 32'(0));
    chk("t5_win0",   32'(bus.win_valid), 32'(0));
    chk("t5_ofm0",   32'(bus.ofm_valid), 32'(0));
    b_ofm = obs_ofm;
    repeat (20) tick();
    chk("t5_no_ofm",  32'(obs_ofm - b_ofm),   32'(0));
    chk("t5_no_done", 32'(obs_done - b_done), 32'(0));
    snap();
    start_job(5, 4);
    stream_until_done(70, -1);
    chk("t5_recover_ofm", 32'(obs_ofm - b_ofm), 32'(6));

    // T6: back-to-back jobs, second start right after done
    tick();
    snap();
    start_job(4, 4);
    stream_until_done(100, -1);
    start_job(3, 4);
    stream_until_done(60, -1);
    chk("t6_jobs", 32'(obs_done - b_done), 32'(2));
    chk("t6_wgt",  32'(obs_wgt - b_wgt),   32'(6));
    chk("t6_ofm",  32'(obs_ofm - b_ofm),   32'(6));
    chk("t6_last", 32'(last_ofm_tag),      32'(16'h0100));

    // a few random jobs
    for (int j = 0; j < 4; j++) begin
      tick();
      snap();
      start_job($urandom_range(3, 7), $urandom_range(3, 6));
      stream_until_done($urandom_range(30, 100), -1);
      chk("rnd_done", 32'(obs_done - b_done), 32'(1));
    end

    repeat (5) tick();
    chk("end_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
